// File: rtl/mram_ctl.sv
// Dual-port record RAM with bulk clear, read handshakes,
// same-address forwarding and a saturating write-collision counter.
module mram_ctl #(
  parameter int RAM_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 1,
  parameter logic [RAM_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear_req,
  output logic                  clear_busy,
  input  logic                  port_a_wr_en,
  input  logic                  port_a_rd_en,
  input  logic [DEPTH_LOG2-1:0] port_a_addr,
  input  logic [RAM_WIDTH-1:0]  port_a_wr_data,
  output logic [RAM_WIDTH-1:0]  port_a_rd_data,
  output logic                  port_a_rd_valid,
  input  logic                  port_b_wr_en,
  input  logic                  port_b_rd_en,
  input  logic [DEPTH_LOG2-1:0] port_b_addr,
  input  logic [RAM_WIDTH-1:0]  port_b_wr_data,
  output logic [RAM_WIDTH-1:0]  port_b_rd_data,
  output logic                  port_b_rd_valid,
  output logic [15:0]           collision_count
);

  typedef logic [DEPTH_LOG2-1:0] addr_t;
  typedef logic [RAM_WIDTH-1:0] word_t;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  generate
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
      $error("mram_ctl: RD_LATENCY must be 1 or 2");
    end
    if (RAM_WIDTH < 1) begin : g_bad_width
      $error("mram_ctl: RAM_WIDTH must be >= 1");
    end
  endgenerate

  logic [0:0]  r_state;
  addr_t       r_clr_addr;
  logic [15:0] r_coll;
  word_t       r_mem [2**DEPTH_LOG2];
  word_t       r_q [2];
  logic [1:0]  r_v1;
  logic [1:0]  r_fs;
  word_t       r_fd [2];

  logic        w_busy;
  logic        w_a_wr;
  logic        w_b_wr;
  logic        w_same;
  logic        w_coll;
  logic [1:0]  w_rd_req;
  logic [1:0]  w_fwd;
  word_t       w_fwd_d [2];
  word_t       w_s1 [2];
  word_t       w_rd [2];
  logic [1:0]  w_rv;
  logic        w_ma_we;
  logic        w_mb_we;
  addr_t       w_ma_addr;
  word_t       w_ma_din;

  assign w_busy = (r_state == S_CLEAR);
  assign w_a_wr = !w_busy && port_a_wr_en;
  assign w_b_wr = !w_busy && port_b_wr_en;
  assign w_same = (port_a_addr == port_b_addr);
  assign w_coll = w_a_wr && w_b_wr && w_same;

  assign w_rd_req[0] = !w_busy && port_a_rd_en;
  assign w_rd_req[1] = !w_busy && port_b_rd_en;

  // Port A wins any same-address write, for both storage and forwarding.
  assign w_fwd[0]   = w_a_wr || (w_b_wr && w_same);
  assign w_fwd_d[0] = w_a_wr ? port_a_wr_data
                             : port_b_wr_data;
  assign w_fwd[1]   = (w_a_wr && w_same) || w_b_wr;
  assign w_fwd_d[1] = (w_a_wr && w_same) ? port_a_wr_data
                                         : port_b_wr_data;

  // The clear engine borrows port A's write path.
  assign w_ma_we   = w_busy || w_a_wr;
  assign w_ma_addr = w_busy ? r_clr_addr : port_a_addr;
  assign w_ma_din  = w_busy ? CLEAR_VALUE : port_a_wr_data;
  assign w_mb_we   = w_b_wr && !w_coll;

  always_ff @(posedge clk) begin
    if (w_ma_we) begin
      r_mem[w_ma_addr] <= w_ma_din;
    end
    if (w_mb_we) begin
      r_mem[port_b_addr] <= port_b_wr_data;
    end
    if (w_rd_req[0]) begin
      r_q[0] <= r_mem[w_ma_addr];
    end
    if (w_rd_req[1]) begin
      r_q[1] <= r_mem[port_b_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_req) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          r_clr_addr <= r_clr_addr + 1'b1;
          if (&r_clr_addr) begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_coll <= '0;
    end else if (r_state == S_IDLE && clear_req) begin
      r_coll <= '0;
    end else if (w_coll && r_coll != 16'hFFFF) begin
      r_coll <= r_coll + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1  <= '0;
      r_fs  <= '0;
      r_fd[0] <= '0;
      r_fd[1] <= '0;
    end else begin
      r_v1 <= w_rd_req;
      for (int p = 0; p < 2; p++) begin
        if (w_rd_req[p]) begin
          r_fs[p] <= w_fwd[p];
          r_fd[p] <= w_fwd_d[p];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_s1[p] = r_fs[p] ? r_fd[p] : r_q[p];
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic [1:0] r_v2;
      word_t      r_out [2];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2     <= '0;
          r_out[0] <= '0;
          r_out[1] <= '0;
        end else begin
          r_v2 <= r_v1;
          for (int p = 0; p < 2; p++) begin
            if (r_v1[p]) begin
              r_out[p] <= w_s1[p];
            end
          end
        end
      end

      assign w_rv    = r_v2;
      assign w_rd[0] = r_out[0];
      assign w_rd[1] = r_out[1];
    end else begin : g_lat1
      word_t r_hold [2];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hold[0] <= '0;
          r_hold[1] <= '0;
        end else begin
          for (int p = 0; p < 2; p++) begin
            if (r_v1[p]) begin
              r_hold[p] <= w_s1[p];
            end
          end
        end
      end

      assign w_rv    = r_v1;
      assign w_rd[0] = r_v1[0] ? w_s1[0] : r_hold[0];
      assign w_rd[1] = r_v1[1] ? w_s1[1] : r_hold[1];
    end
  endgenerate

  assign clear_busy      = w_busy;
  assign collision_count = r_coll;
  assign port_a_rd_data  = w_rd[0];
  assign port_a_rd_valid = w_rv[0];
  assign port_b_rd_data  = w_rd[1];
  assign port_b_rd_valid = w_rv[1];

endmodule

// File: tb/tb_mram_ctl.sv
// Scoreboard bench for mram_ctl: u1 at read latency 1,
// u2 at read latency 2, both depth 1024.
module tb_mram_ctl;

  localparam logic [63:0] CV = 64'hC1EA_0000_5A5A_0001;

  typedef struct {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;

  logic        c1_req, c1_busy, c2_req, c2_busy;
  logic        a1_we, a1_re, b1_we, b1_re;
  logic        a2_we, a2_re, b2_we, b2_re;
  logic [9:0]  a1_ad, b1_ad, a2_ad, b2_ad;
  logic [63:0] a1_wd, b1_wd, a2_wd, b2_wd;
  logic [63:0] a1_rd, b1_rd, a2_rd, b2_rd;
  logic        a1_v, b1_v, a2_v, b2_v;
  logic [15:0] cnt1, cnt2;

  exp_t  sb [4][$];
  exp_t  mon_e;
  string pn [4] = '{"u1.A", "u1.B", "u2.A", "u2.B"};
  logic        v [4];
  logic [63:0] d [4];

  assign v[0] = a1_v;
  assign v[1] = b1_v;
  assign v[2] = a2_v;
  assign v[3] = b2_v;
  assign d[0] = a1_rd;
  assign d[1] = b1_rd;
  assign d[2] = a2_rd;
  assign d[3] = b2_rd;

  mram_ctl #(
    .RAM_WIDTH(64), .DEPTH_LOG2(10),
    .RD_LATENCY(1), .CLEAR_VALUE(CV)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .clear_req(c1_req), .clear_busy(c1_busy),
    .port_a_wr_en(a1_we), .port_a_rd_en(a1_re),
    .port_a_addr(a1_ad), .port_a_wr_data(a1_wd),
    .port_a_rd_data(a1_rd), .port_a_rd_valid(a1_v),
    .port_b_wr_en(b1_we), .port_b_rd_en(b1_re),
    .port_b_addr(b1_ad), .port_b_wr_data(b1_wd),
    .port_b_rd_data(b1_rd), .port_b_rd_valid(b1_v),
    .collision_count(cnt1)
  );

  mram_ctl #(
    .RAM_WIDTH(64), .DEPTH_LOG2(10),
    .RD_LATENCY(2), .CLEAR_VALUE(CV)
  ) u2 (
    .clk(clk), .reset_n(reset_n),
    .clear_req(c2_req), .clear_busy(c2_busy),
    .port_a_wr_en(a2_we), .port_a_rd_en(a2_re),
    .port_a_addr(a2_ad), .port_a_wr_data(a2_wd),
    .port_a_rd_data(a2_rd), .port_a_rd_valid(a2_v),
    .port_b_wr_en(b2_we), .port_b_rd_en(b2_re),
    .port_b_addr(b2_ad), .port_b_wr_data(b2_wd),
    .port_b_rd_data(b2_rd), .port_b_rd_valid(b2_v),
    .collision_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic cmp(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ncmp++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Monitor: pops on every rd_valid and flags missed responses.
  always @(negedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (v[p]) begin
        if (sb[p].size() == 0) begin
          ncmp++;
          nfail++;
          $display("FAIL %s unexpected rd_valid: got data %h expected none",
                   pn[p], d[p]);
        end else begin
          mon_e = sb[p].pop_front();
          cmp({pn[p], ".data"}, d[p], mon_e.d);
          cmp({pn[p], ".cycle"}, 64'(cyc), 64'(mon_e.due));
        end
      end else if (sb[p].size() > 0 && sb[p][0].due <= cyc) begin
        mon_e = sb[p].pop_front();
        ncmp++;
        nfail++;
        $display("FAIL %s missing rd_valid: got none expected %h at cycle %0d",
                 pn[p], mon_e.d, mon_e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle1();
    a1_we = 0; a1_re = 0; a1_ad = '0; a1_wd = '0;
    b1_we = 0; b1_re = 0; b1_ad = '0; b1_wd = '0;
  endtask

  task automatic idle2();
    a2_we = 0; a2_re = 0; a2_ad = '0; a2_wd = '0;
    b2_we = 0; b2_re = 0; b2_ad = '0; b2_wd = '0;
  endtask

  task automatic op1(input logic aw, input logic ar,
                     input logic [9:0] aa, input logic [63:0] awd,
                     input logic bw, input logic br,
                     input logic [9:0] ba, input logic [63:0] bwd,
                     input logic [63:0] ea, input logic [63:0] eb);
    a1_we = aw; a1_re = ar; a1_ad = aa; a1_wd = awd;
    b1_we = bw; b1_re = br; b1_ad = ba; b1_wd = bwd;
    if (ar) sb[0].push_back('{ea, cyc + 1});
    if (br) sb[1].push_back('{eb, cyc + 1});
    tick();
    idle1();
  endtask

  task automatic op2(input logic aw, input logic ar,
                     input logic [9:0] aa, input logic [63:0] awd,
                     input logic bw, input logic br,
                     input logic [9:0] ba, input logic [63:0] bwd,
                     input logic [63:0] ea, input logic [63:0] eb);
    a2_we = aw; a2_re = ar; a2_ad = aa; a2_wd = awd;
    b2_we = bw; b2_re = br; b2_ad = ba; b2_wd = bwd;
    if (ar) sb[2].push_back('{ea, cyc + 2});
    if (br) sb[3].push_back('{eb, cyc + 2});
    tick();
    idle2();
  endtask

  initial begin
    int n;
    reset_n = 1'b1;
    c1_req = 0;
    c2_req = 0;
    idle1();
    idle2();
    #1 reset_n = 1'b0;
    #1;
    cmp("rst.busy", 64'(c1_busy), 64'd1);
    cmp("rst.a_valid", 64'(a1_v), 64'd0);
    cmp("rst.b_valid", 64'(b1_v), 64'd0);
    cmp("rst.a_data", a1_rd, 64'd0);
    cmp("rst.b_data", b1_rd, 64'd0);
    cmp("rst.count", 64'(cnt1), 64'd0);
    cmp("rst.u2_valid", 64'(a2_v), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;

    n = 0;
    while (c1_busy && n < 5000) begin
      n++;
      tick();
    end
    cmp("init_clear_len", 64'(n), 64'd1024);
    cmp("u2.init_busy", 64'(c2_busy), 64'd0);

    // Cleared contents, both ports, back to back.
    op1(0, 1, 10'd0,    0, 0, 1, 10'd511, 0, CV, CV);
    op1(0, 1, 10'd511,  0, 0, 1, 10'd1023, 0, CV, CV);
    op1(0, 1, 10'd1023, 0, 0, 0, 10'd0, 0, CV, 0);

    // Cross-port and same-port forwarding.
    op1(1, 0, 10'd7, 64'hA5, 0, 1, 10'd7, 0, 0, 64'hA5);
    op1(0, 1, 10'd8, 0, 1, 0, 10'd8, 64'h3C, 64'h3C, 0);
    op1(1, 1, 10'd12, 64'h77, 0, 0, 10'd0, 0, 64'h77, 0);
    op1(0, 0, 10'd0, 0, 1, 1, 10'd30, 64'hB0, 0, 64'hB0);

    // Dual writes to one address: A wins, counter steps.
    op1(1, 0, 10'd3, 64'h11, 1, 0, 10'd3, 64'h22, 0, 0);
    cmp("coll.count1", 64'(cnt1), 64'd1);
    op1(0, 1, 10'd3, 0, 0, 0, 10'd0, 0, 64'h11, 0);
    op1(1, 0, 10'd3, 64'h33, 1, 1, 10'd3, 64'h44, 0, 64'h33);
    cmp("coll.count2", 64'(cnt1), 64'd2);
    op1(0, 1, 10'd3, 0, 0, 1, 10'd3, 0, 64'h33, 64'h33);
    cmp("coll.both_read", 64'(cnt1), 64'd2);

    op1(1, 0, 10'd20, 64'h20, 1, 0, 10'd21, 64'h21, 0, 0);
    op1(0, 1, 10'd21, 0, 0, 1, 10'd20, 0, 64'h21, 64'h20);
    cmp("indep.count", 64'(cnt1), 64'd2);
    tick();
    tick();
    cmp("hold.a_data", a1_rd, 64'h21);
    cmp("hold.b_data", b1_rd, 64'h20);
    cmp("hold.a_valid", 64'(a1_v), 64'd0);

    // Saturation.
    a1_we = 1; a1_ad = 10'd3; a1_wd = 64'h1;
    b1_we = 1; b1_ad = 10'd3; b1_wd = 64'h2;
    repeat (70000) tick();
    idle1();
    cmp("coll.saturate", 64'(cnt1), 64'hFFFF);
    op1(0, 1, 10'd3, 0, 0, 0, 10'd0, 0, 64'h1, 0);
    tick();
    cmp("coll.sat_hold", 64'(cnt1), 64'hFFFF);

    // Latency-2 instance: streaming reads and forwarding.
    for (int i = 0; i < 16; i++)
      op2(0, 0, 10'd0, 0, 1, 0, 10'(i), 64'(256 + i), 0, 0);
    for (int i = 0; i < 16; i++)
      op2(0, 1, 10'(i), 0, 0, 0, 10'd0, 0, 64'(256 + i), 0);
    op2(0, 1, 10'd5, 0, 0, 0, 10'd0, 0, 64'h105, 0);
    op2(0, 0, 10'd0, 0, 1, 0, 10'd5, 64'hBAD, 0, 0);
    op2(0, 1, 10'd5, 0, 0, 0, 10'd0, 0, 64'hBAD, 0);
    op2(1, 0, 10'd6, 64'hF0, 0, 1, 10'd6, 0, 0, 64'hF0);
    repeat (4) tick();

    // Clear on request with traffic and a second request mid-clear.
    op1(1, 0, 10'd9, 64'h5, 0, 0, 10'd0, 0, 0, 0);
    c1_req = 1;
    tick();
    c1_req = 0;
    cmp("clr.busy", 64'(c1_busy), 64'd1);
    cmp("clr.count_zero", 64'(cnt1), 64'd0);
    n = 0;
    while (c1_busy && n < 5000) begin
      if (n < 20) begin
        a1_we = 1; a1_re = 1; a1_ad = 10'd9; a1_wd = 64'h99;
        b1_we = 1; b1_re = 1; b1_ad = 10'd9; b1_wd = 64'h98;
      end else begin
        idle1();
      end
      c1_req = (n == 500);
      n++;
      tick();
    end
    c1_req = 0;
    idle1();
    cmp("clr.len", 64'(n), 64'd1024);
    op1(0, 1, 10'd9, 0, 0, 1, 10'd3, 0, CV, CV);
    cmp("clr.count_after", 64'(cnt1), 64'd0);
    tick();

    // Reset in the middle of a clear.
    c1_req = 1;
    tick();
    c1_req = 0;
    repeat (300) tick();
    #2 reset_n = 1'b0;
    #1;
    cmp("midrst.a_data", a1_rd, 64'd0);
    cmp("midrst.b_data", b1_rd, 64'd0);
    cmp("midrst.u2_data", a2_rd, 64'd0);
    cmp("midrst.busy", 64'(c1_busy), 64'd1);
    cmp("midrst.valid", 64'(a1_v), 64'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    n = 0;
    while (c1_busy && n < 5000) begin
      n++;
      tick();
    end
    cmp("midrst.clear_len", 64'(n), 64'd1024);
    op1(0, 1, 10'd0, 0, 0, 0, 10'd0, 0, CV, 0);

    repeat (4) tick();
    for (int p = 0; p < 4; p++)
      cmp({pn[p], ".leftover"}, 64'(sb[p].size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mram_ctl.md
Name: mram_ctl

Overview:
- Parametrised successor to the inferred dual-port position RAM; sits between the move generator / evaluator pipelines and Block RAM holding per-position records.
- Adds:
  - a hardware bulk-clear state machine, run after reset and on request;
  - explicit read-enable / read-valid handshakes with selectable read latency;
  - defined same-address collision behaviour: write forwarding, port A priority, and a saturating collision counter.
- The storage array stays inferable as true dual-port Block RAM; all extra logic lives outside the array.

Parameters:
- RAM_WIDTH, 64, data word width in bits (must be >= 1).
- DEPTH_LOG2, 10, address width; depth = 2**DEPTH_LOG2 entries.
- RD_LATENCY, 1, read latency in cycles; legal values 1 or 2 (2 adds an output register); any other value is an elaboration error.
- CLEAR_VALUE, 0, RAM_WIDTH-bit value written to every entry by a clear.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse; starts a bulk clear when idle.
- clear_busy  out  1  high while a clear is in progress.
- port_a_wr_en  in  1  port A write strobe.
- port_a_rd_en  in  1  port A read strobe.
- port_a_addr  in  DEPTH_LOG2  port A address.
- port_a_wr_data  in  RAM_WIDTH  port A write data.
- port_a_rd_data  out  RAM_WIDTH  port A read data.
- port_a_rd_valid  out  1  port A read data valid.
- port_b_wr_en, port_b_rd_en, port_b_addr, port_b_wr_data, port_b_rd_data, port_b_rd_valid  same as port A, for port B.
- collision_count  out  16  saturating count of same-address dual writes.

Behaviour:
- Reset (reset_n low, asynchronous):
  - clear_busy=1, all rd_valid=0, all rd_data=0, collision_count=0;
  - clear FSM enters CLEAR with clear_addr=0;
  - in-flight read pipeline is flushed;
  - the array itself has no reset.
- FSM states IDLE and CLEAR:
  - CLEAR: write CLEAR_VALUE to mem[clear_addr] each cycle, clear_addr+1; after writing 2**DEPTH_LOG2-1, go to IDLE next cycle and drop clear_busy. A clear lasts exactly 2**DEPTH_LOG2 cycles.
  - IDLE: clear_req=1 enters CLEAR next cycle with clear_addr=0 and clears collision_count to 0.
  - clear_req during CLEAR is ignored (clear is not restarted).
  - reset_n asserted mid-clear restarts the clear from address 0 after release.
- While clear_busy=1, external wr_en and rd_en are ignored: no array write, and no rd_valid for reads requested in those cycles.
- Read handshake:
  - rd_en sampled at cycle N gives rd_valid=1 and rd_data at cycle N+RD_LATENCY, for one cycle per request.
  - Back-to-back reads every cycle are supported at full throughput.
  - When rd_valid=0, rd_data holds its last value.
- Same-port read and write to one address in one cycle: write-first; the read returns the new data.
- Cross-port, same cycle, same address (IDLE only):
  - Both write: port A data is stored and port B's write is dropped; collision_count increments, saturating at 16'hFFFF.
  - One port writes, the other reads: the read returns the written data (forwarding mux, not a BRAM-mode dependency).
  - Both write and either reads: the read returns port A data.
  - Both read: both get the stored data; no collision.
- Different addresses: the ports are fully independent.
- Forwarding decisions use inputs from the request cycle only; writes in later cycles do not alter an in-flight read under RD_LATENCY=2.
- Widths: addresses are unsigned, with no wrap beyond depth (the address range is exactly the depth).

Test Plan:
- Reset release, then poll: clear_busy stays high for exactly 1024 cycles (DEPTH_LOG2=10); reads of addresses 0, 511 and 1023 afterwards return CLEAR_VALUE, each with rd_valid at N+1.
- Port A writes 0xA5 at addr 7 while port B reads addr 7 in the same cycle: port_b_rd_data=0xA5 with rd_valid at N+RD_LATENCY.
- Both ports write addr 3 (A=0x11, B=0x22) in the same cycle: a subsequent read of addr 3 returns 0x11; collision_count=1. Repeat 70000 times: collision_count=0xFFFF.
- RD_LATENCY=2: port A reads addr 0..15 on 16 consecutive cycles: 16 consecutive rd_valid pulses starting 2 cycles after the first rd_en, data in order, no gaps.
- Write 0x5 at addr 9, pulse clear_req, attempt writes and reads during busy: no rd_valid during busy, and a read of addr 9 after busy returns CLEAR_VALUE. A second clear_req mid-clear does not extend clear_busy beyond 1024 cycles.
- Assert reset_n low 300 cycles into a clear: outputs zero immediately (asynchronously); after release, clear_busy is high for a full 1024 cycles again.
